btb_resolve_unit: RTL
=====================

# btb_resolve_unit

Consumes the branch-prediction bundle carried down the pipeline from the fetch-side prediction register (2-bit counter, fetch PC, predicted target) at execute, and compares it against the actual branch outcome. On disagreement it issues a one-cycle mispredict/redirect pulse to fetch. For every resolved branch it computes the updated BTB entry and queues it in a small FIFO that drains into the BTB write port under a valid/ready handshake. It also keeps branch and mispredict statistics.

## Interface
- DEPTH, 4, write-queue entries (power of two, ≥2)
- IDX_BITS, 6, BTB index width; index = Address[IDX_BITS+1:2], tag = Address[31:IDX_BITS+2]

Ports:
- Clk  in  1  clock; all state updates on posedge Clk
- Rst  in  1  reset, synchronous, active-high
- ExBranch  in  1  a conditional branch resolves this cycle
- ExTaken  in  1  actual direction
- ExTarget  in  32  actual taken target
- ExBP  in  2  counter from the prediction bundle (00 SNT, 01 WNT, 10 WT, 11 ST)
- ExAddress  in  32  branch PC from the bundle
- ExBTBInstruction  in  32  predicted target from the bundle
- Mispredict  out  1  registered one-cycle pulse
- RedirectPC  out  32  correct next PC, valid while Mispredict=1
- BTBWrValid  out  1  queue head valid
- BTBWrReady  in  1  BTB accepts the write
- BTBWrIndex  out  IDX_BITS  head index
- BTBWrTag  out  32-IDX_BITS-2  head tag
- BTBWrTarget  out  32  head target
- BTBWrBP  out  2  head updated counter
- BranchCount  out  32  resolved branches, wraps
- MispredictCount  out  32  mispredicts, wraps
- DropCount  out  16  updates lost to a full queue, saturates at 0xFFFF

## Operation
- Predicted taken = ExBP[1].
- Mispredict condition = ExBranch & ((ExTaken != ExBP[1]) | (ExTaken & ExBP[1] & (ExTarget != ExBTBInstruction))).
- RedirectPC = ExTaken ? ExTarget : ExAddress + 4 (32-bit modulo).
- New counter: saturating increment if taken (11 stays 11), decrement if not taken (00 stays 00).
- Queued target = ExTaken ? ExTarget : ExBTBInstruction. A not-taken branch keeps the old target.
- Each ExBranch cycle pushes {index, tag, target, new counter}.
- Pop when BTBWrValid & BTBWrReady. BTBWrValid = !empty. Head outputs come straight from storage and hold stable while BTBWrValid=1 and BTBWrReady=0.
- Full with no pop in the same cycle: the push is dropped and DropCount increments. Mispredict and the other counters still update.
- Full with a pop in the same cycle: the push is accepted and the occupancy stays DEPTH.
- Empty queue: push and pop never coincide on the same entry. No bypass; a pushed entry is visible at the head the following cycle.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter with log2(DEPTH)+1 bits gives full/empty.
- BranchCount increments on every ExBranch. MispredictCount increments on every mispredict condition.

## Timing
- Reset: Mispredict=0, RedirectPC=0, BTBWrValid=0, queue empty (pointers and occupancy 0), head fields 0, all counters 0.
- Rst asserted mid-operation discards queued entries, including an entry currently being offered. Inputs are ignored during the Rst cycle.
- Latency: resolution in cycle N → Mispredict/RedirectPC in cycle N+1 for exactly one cycle.
  - Back-to-back mispredicts give back-to-back pulses, each with its own RedirectPC.
- Latency: push in cycle N → BTBWrValid earliest in cycle N+1. Throughput is one write per cycle with BTBWrReady held high.
- Counters are registered and reflect the resolution in cycle N from cycle N+1.

## Structure
- Shared package mips_bp_pkg holds:
  - counter encodings SNT/WNT/WT/ST;
  - function bp_next(bp, taken);
  - a BTB write-entry struct/width constant.
- The fetch-side prediction register uses the same package.
- Sub-module btb_wr_fifo (parameters DEPTH, WIDTH) owns storage, pointers, occupancy and the full-with-pop rule. The top level holds the compare, redirect and counter logic.

## Test plan
- ExBP=10, ExTaken=1, ExTarget=ExBTBInstruction=0x400 → no Mispredict; queued BP=11, target 0x400; BranchCount=1.
- ExBP=11, ExTaken=0, ExAddress=0x100 → Mispredict pulse next cycle with RedirectPC=0x104; queued BP=10; MispredictCount=1.
- ExBP=11, ExTaken=1, ExBTBInstruction=0x200, ExTarget=0x300 → RedirectPC=0x300; queued target 0x300, BP=11.
- BTBWrReady=0 with 5 branches and DEPTH=4 → 4 queued, DropCount=1. Then BTBWrReady=1 → 4 writes in FIFO order on consecutive cycles, then BTBWrValid=0.
- Queue full, ExBranch and BTBWrReady=1 in the same cycle → push accepted, DropCount unchanged, occupancy stays 4.
- Rst asserted with 3 entries queued and a Mispredict pending → next cycle all outputs and counters are at their reset values.

Source files
------------

// File: rtl/mips_bp_pkg.sv
// Branch-prediction types shared by the fetch-side prediction register and the execute-side resolve unit.
// Holds the 2-bit counter encoding, its update rule and the BTB write-entry layout.
package mips_bp_pkg;

   typedef enum logic [1:0] {
      BP_SNT = 2'b00,
      BP_WNT = 2'b01,
      BP_WT  = 2'b10,
      BP_ST  = 2'b11
   } bpState_t;

   // pcBits is Address[31:2]: the low IDX_BITS form the index, the rest the tag
   typedef struct packed {
      logic [29:0] pcBits;
      logic [31:0] target;
      bpState_t    bp;
   } btbWrEntry_t;

   localparam int BTB_WR_ENTRY_W = $bits(btbWrEntry_t);

   function automatic bpState_t bp_next(input bpState_t bp, input logic taken);
      bpState_t result;
      result = bp;
      if (taken) begin
         if (bp != BP_ST) result = bpState_t'(bp + 2'd1);
      end else begin
         if (bp != BP_SNT) result = bpState_t'(bp - 2'd1);
      end
      return result;
   endfunction

endpackage

// File: rtl/btb_resolve_unit_if.sv
// BTB write port: the resolve unit offers queued entries, the BTB accepts them with BTBWrReady.
interface btb_resolve_unit_if
   import mips_bp_pkg::*;
#(
   parameter int IDX_BITS = 6
) ();

   logic                     BTBWrValid;
   logic                     BTBWrReady;
   logic [IDX_BITS-1:0]      BTBWrIndex;
   logic [32-IDX_BITS-3:0]   BTBWrTag;
   logic [31:0]              BTBWrTarget;
   bpState_t                 BTBWrBP;

   modport master (
      output BTBWrValid, BTBWrIndex, BTBWrTag, BTBWrTarget, BTBWrBP,
      input  BTBWrReady
   );

   modport slave (
      input  BTBWrValid, BTBWrIndex, BTBWrTag, BTBWrTarget, BTBWrBP,
      output BTBWrReady
   );

endinterface

// File: rtl/btb_wr_fifo.sv
// Small FIFO holding pending BTB updates; a push into a full queue is accepted only when a pop frees a slot.
module btb_wr_fifo
   import mips_bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = BTB_WR_ENTRY_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_pushValid,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_popReady,
   output logic             o_headValid,
   output logic [WIDTH-1:0] o_headData,
   output logic             o_full,
   output logic             o_pop
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W:0]   r_count;

   logic w_empty;
   logic w_pushAccept;

   assign w_empty      = (r_count == '0);
   assign o_full       = (r_count == (PTR_W+1)'(DEPTH));
   assign o_headValid  = !w_empty;
   assign o_pop        = o_headValid & i_popReady;
   assign w_pushAccept = i_pushValid & (!o_full | o_pop);
   // Gating with empty keeps the head fields at zero out of reset without clearing storage
   assign o_headData   = w_empty ? '0 : r_mem[r_rdPtr];

   always_ff @(posedge clk) begin
      if (!rst && w_pushAccept) r_mem[r_wrPtr] <= i_pushData;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushAccept) r_wrPtr <= r_wrPtr + 1'b1;
         if (o_pop)        r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_pushAccept, o_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/btb_resolve_unit.sv
// Execute-stage branch resolution: compares the carried prediction with the real outcome,
// pulses a redirect on mispredict, queues the BTB update and keeps branch statistics.
module btb_resolve_unit
   import mips_bp_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int IDX_BITS = 6
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        ExBranch,
   input  logic        ExTaken,
   input  logic [31:0] ExTarget,
   input  logic [1:0]  ExBP,
   input  logic [31:0] ExAddress,
   input  logic [31:0] ExBTBInstruction,
   output logic        Mispredict,
   output logic [31:0] RedirectPC,
   output logic [31:0] BranchCount,
   output logic [31:0] MispredictCount,
   output logic [15:0] DropCount,
   btb_resolve_unit_if.master btbWr
);

   logic                      r_mispredict;
   logic [31:0]               r_redirectPC;
   logic [31:0]               r_branchCount;
   logic [31:0]               r_mispredictCount;
   logic [15:0]               r_dropCount;

   logic                      w_predTaken;
   logic                      w_mispredictCond;
   logic [31:0]               w_redirectPC;
   btbWrEntry_t               w_entry;
   btbWrEntry_t               w_headEntry;
   logic [BTB_WR_ENTRY_W-1:0] w_headData;
   logic                      w_headValid;
   logic                      w_full;
   logic                      w_pop;
   logic                      w_drop;

   assign w_predTaken      = ExBP[1];
   // A correctly predicted taken branch still mispredicts if the BTB target was stale
   assign w_mispredictCond = ExBranch & ((ExTaken != w_predTaken) |
                                         (ExTaken & w_predTaken & (ExTarget != ExBTBInstruction)));
   assign w_redirectPC     = ExTaken ? ExTarget : (ExAddress + 32'd4);
   assign w_drop           = ExBranch & w_full & !w_pop;

   always_comb begin
      w_entry        = '0;
      w_entry.pcBits = ExAddress[31:2];
      w_entry.target = ExTaken ? ExTarget : ExBTBInstruction;
      w_entry.bp     = bp_next(bpState_t'(ExBP), ExTaken);
   end

   btb_wr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BTB_WR_ENTRY_W)
   ) u_fifo (
      .clk         (Clk),
      .rst         (Rst),
      .i_pushValid (ExBranch),
      .i_pushData  (w_entry),
      .i_popReady  (btbWr.BTBWrReady),
      .o_headValid (w_headValid),
      .o_headData  (w_headData),
      .o_full      (w_full),
      .o_pop       (w_pop)
   );

   assign w_headEntry       = btbWrEntry_t'(w_headData);
   assign btbWr.BTBWrValid  = w_headValid;
   assign btbWr.BTBWrIndex  = w_headEntry.pcBits[IDX_BITS-1:0];
   assign btbWr.BTBWrTag    = w_headEntry.pcBits[29:IDX_BITS];
   assign btbWr.BTBWrTarget = w_headEntry.target;
   assign btbWr.BTBWrBP     = w_headEntry.bp;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_mispredict      <= 1'b0;
         r_redirectPC      <= '0;
         r_branchCount     <= '0;
         r_mispredictCount <= '0;
         r_dropCount       <= '0;
      end else begin
         r_mispredict <= w_mispredictCond;
         if (w_mispredictCond) r_redirectPC <= w_redirectPC;
         if (ExBranch)         r_branchCount <= r_branchCount + 32'd1;
         if (w_mispredictCond) r_mispredictCount <= r_mispredictCount + 32'd1;
         if (w_drop && (r_dropCount != 16'hFFFF)) r_dropCount <= r_dropCount + 16'd1;
      end
   end

   assign Mispredict      = r_mispredict;
   assign RedirectPC      = r_redirectPC;
   assign BranchCount     = r_branchCount;
   assign MispredictCount = r_mispredictCount;
   assign DropCount       = r_dropCount;

endmodule
